// File: rtl/csr_counter_bank.sv
// Parametrised bank of CSR-accessible event counters with per-counter event select and inhibit.
// Define CSR_COUNTER_OVERFLOW_EN to add sticky overflow flags and the overflow interrupt.
module csr_counter_bank #(
  parameter int unsigned COUNTER_COUNT    = 4,
  parameter int unsigned COUNTER_WIDTH    = 64,
  parameter int unsigned EVENT_COUNT      = 16,
  parameter logic [11:0] ADDRESS_LOWER    = 12'hB03,
  parameter logic [11:0] ADDRESS_UPPER    = 12'hB83,
  parameter logic [11:0] ADDRESS_EVENT    = 12'h323,
  parameter logic [11:0] ADDRESS_INHIBIT  = 12'h320,
  parameter logic [11:0] ADDRESS_OVERFLOW = 12'h7C0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     csrWriteEnable,
  input  logic                     csrReadEnable,
  input  logic [11:0]              csrAddress,
  input  logic [31:0]              csrWriteData,
  output logic [31:0]              csrReadData,
  output logic                     csrRequestOutput,
  input  logic [EVENT_COUNT-1:0]   events,
  output logic [COUNTER_COUNT-1:0] counterOverflow,
  output logic                     overflowInterrupt
);

  localparam int unsigned SEL_W   = $clog2(EVENT_COUNT + 1);
  localparam int unsigned UPPER_W = COUNTER_WIDTH - 32;
  localparam logic [COUNTER_WIDTH-1:0] ONE = 1;

  logic [COUNTER_WIDTH-1:0] count [COUNTER_COUNT];
  logic [SEL_W-1:0]         sel   [COUNTER_COUNT];
  logic [COUNTER_COUNT-1:0] inhibit;
  logic [COUNTER_COUNT-1:0] overflow;
  logic [COUNTER_COUNT-1:0] wr_lower, wr_upper, wr_sel, inc;
  logic                     wr_inhibit;
  logic [EVENT_COUNT:0]     event_ext;
  logic [31:0]              rdata;
  logic                     hit;

  // Select value 0 maps onto the constant-zero slot, so only v > EVENT_COUNT needs a guard.
  assign event_ext = {events, 1'b0};

  always_comb begin
    wr_lower   = '0;
    wr_upper   = '0;
    wr_sel     = '0;
    inc        = '0;
    wr_inhibit = csrWriteEnable && (csrAddress == ADDRESS_INHIBIT);
    for (int unsigned n = 0; n < COUNTER_COUNT; n++) begin
      wr_lower[n] = csrWriteEnable && (csrAddress == ADDRESS_LOWER + 12'(n));
      wr_upper[n] = csrWriteEnable && (csrAddress == ADDRESS_UPPER + 12'(n));
      wr_sel[n]   = csrWriteEnable && (csrAddress == ADDRESS_EVENT + 12'(n));
      inc[n]      = !inhibit[n] && (32'(sel[n]) <= EVENT_COUNT) && event_ext[sel[n]];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned n = 0; n < COUNTER_COUNT; n++) begin
        count[n] <= '0;
        sel[n]   <= '0;
      end
      inhibit <= '0;
    end else begin
      for (int unsigned n = 0; n < COUNTER_COUNT; n++) begin
        if (wr_lower[n])
          count[n][31:0] <= csrWriteData;
        else if (wr_upper[n])
          count[n][COUNTER_WIDTH-1:32] <= csrWriteData[UPPER_W-1:0];
        else if (inc[n])
          count[n] <= count[n] + ONE;
        if (wr_sel[n])
          sel[n] <= csrWriteData[SEL_W-1:0];
        if (wr_inhibit)
          inhibit[n] <= csrWriteData[n+3];
      end
    end
  end

`ifdef CSR_COUNTER_OVERFLOW_EN
  localparam bit HAS_OVERFLOW = 1'b1;

  logic [COUNTER_COUNT-1:0] wrap;
  logic                     wr_overflow;

  assign wr_overflow = csrWriteEnable && (csrAddress == ADDRESS_OVERFLOW);

  always_comb begin
    wrap = '0;
    for (int unsigned n = 0; n < COUNTER_COUNT; n++)
      wrap[n] = inc[n] && (&count[n]) && !wr_lower[n] && !wr_upper[n];
  end

  // Set is tested first so it overrides a same-cycle write-1-to-clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= '0;
    end else begin
      for (int unsigned n = 0; n < COUNTER_COUNT; n++) begin
        if (wrap[n])
          overflow[n] <= 1'b1;
        else if (wr_overflow && csrWriteData[n+3])
          overflow[n] <= 1'b0;
      end
    end
  end
`else
  localparam bit HAS_OVERFLOW = 1'b0;

  assign overflow = '0;
`endif

  assign counterOverflow   = overflow;
  assign overflowInterrupt = |overflow;

  always_comb begin
    hit   = 1'b0;
    rdata = '0;
    for (int unsigned n = 0; n < COUNTER_COUNT; n++) begin
      if (csrAddress == ADDRESS_LOWER + 12'(n)) begin
        hit   = 1'b1;
        rdata = count[n][31:0];
      end
      if (csrAddress == ADDRESS_UPPER + 12'(n)) begin
        hit   = 1'b1;
        rdata = 32'(count[n][COUNTER_WIDTH-1:32]);
      end
      if (csrAddress == ADDRESS_EVENT + 12'(n)) begin
        hit   = 1'b1;
        rdata = 32'(sel[n]);
      end
    end
    if (csrAddress == ADDRESS_INHIBIT) begin
      hit = 1'b1;
      for (int unsigned n = 0; n < COUNTER_COUNT; n++)
        rdata[n+3] = inhibit[n];
    end
    if (HAS_OVERFLOW && (csrAddress == ADDRESS_OVERFLOW)) begin
      hit = 1'b1;
      for (int unsigned n = 0; n < COUNTER_COUNT; n++)
        rdata[n+3] = overflow[n];
    end
  end

  assign csrRequestOutput = rst && csrReadEnable && hit;
  assign csrReadData      = csrRequestOutput ? rdata : '0;

endmodule

// File: tb/tb_csr_counter_bank.sv
// Randomised and directed bench for csr_counter_bank against an array-based model of the counter bank.
// Overflow checks follow CSR_COUNTER_OVERFLOW_EN when defined.
module tb_csr_counter_bank;

  localparam int C = 4;
  localparam int W = 48;
  localparam int E = 16;
  localparam int SELMOD = 1 << $clog2(E + 1);
  localparam logic [11:0] LO  = 12'hB03;
  localparam logic [11:0] HI  = 12'hB83;
  localparam logic [11:0] EVA = 12'h323;
  localparam logic [11:0] INH = 12'h320;
  localparam logic [11:0] OVF = 12'h7C0;
  localparam logic [63:0] MASK = (64'd1 << W) - 64'd1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          we = 1'b0;
  logic          re = 1'b0;
  logic [11:0]   addr = '0;
  logic [31:0]   wd = '0;
  logic [E-1:0]  ev = '0;
  logic [31:0]   rd;
  logic          req;
  logic [C-1:0]  covf;
  logic          oint;

  csr_counter_bank #(
    .COUNTER_COUNT(C), .COUNTER_WIDTH(W), .EVENT_COUNT(E),
    .ADDRESS_LOWER(LO), .ADDRESS_UPPER(HI), .ADDRESS_EVENT(EVA),
    .ADDRESS_INHIBIT(INH), .ADDRESS_OVERFLOW(OVF)
  ) dut (
    .clk(clk), .rst(rst), .csrWriteEnable(we), .csrReadEnable(re),
    .csrAddress(addr), .csrWriteData(wd), .csrReadData(rd),
    .csrRequestOutput(req), .events(ev), .counterOverflow(covf),
    .overflowInterrupt(oint)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain arrays updated once per rising edge.
  logic [63:0] m_cnt [C];
  int          m_sel [C];
  bit          m_inh [C];
  bit          m_ovf [C];
  bit          counting, wrapped;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int n = 0; n < C; n++) begin
        m_cnt[n] = 0; m_sel[n] = 0; m_inh[n] = 0; m_ovf[n] = 0;
      end
    end else begin
      for (int n = 0; n < C; n++) begin
        counting = (m_sel[n] >= 1) && (m_sel[n] <= E) && ev[m_sel[n]-1] && !m_inh[n];
        wrapped  = 0;
        if (we && addr == LO + n)
          m_cnt[n] = (m_cnt[n] & ~64'hFFFF_FFFF) | 64'(wd);
        else if (we && addr == HI + n)
          m_cnt[n] = ((m_cnt[n] & 64'hFFFF_FFFF) | (64'(wd) << 32)) & MASK;
        else if (counting) begin
          m_cnt[n] = (m_cnt[n] + 1) & MASK;
          wrapped  = (m_cnt[n] == 0);
        end
`ifdef CSR_COUNTER_OVERFLOW_EN
        if (we && addr == OVF && wd[n+3]) m_ovf[n] = 0;
        if (wrapped) m_ovf[n] = 1;
`endif
        if (we && addr == EVA + n) m_sel[n] = int'(wd % SELMOD);
        if (we && addr == INH) m_inh[n] = wd[n+3];
      end
    end
  end

  function automatic logic [32:0] mread(input logic [11:0] a);
    logic [31:0] d = '0;
    bit h = 0;
    for (int n = 0; n < C; n++) begin
      if (a == LO + n)  begin h = 1; d = m_cnt[n][31:0]; end
      if (a == HI + n)  begin h = 1; d = m_cnt[n][63:32]; end
      if (a == EVA + n) begin h = 1; d = 32'(m_sel[n]); end
    end
    if (a == INH) begin
      h = 1;
      for (int n = 0; n < C; n++) d[n+3] = m_inh[n];
    end
`ifdef CSR_COUNTER_OVERFLOW_EN
    if (a == OVF) begin
      h = 1;
      for (int n = 0; n < C; n++) d[n+3] = m_ovf[n];
    end
`endif
    return {h, d};
  endfunction

  function automatic logic [C-1:0] mflags();
    logic [C-1:0] f = '0;
    for (int n = 0; n < C; n++) f[n] = m_ovf[n];
    return f;
  endfunction

  logic [32:0] cmp_m;
  logic        cmp_req;

  always @(negedge clk) begin
    cmp_m   = mread(addr);
    cmp_req = rst && re && cmp_m[32];
    check("cyc_req", 64'(req), 64'(cmp_req));
    check("cyc_rdata", 64'(rd), cmp_req ? 64'(cmp_m[31:0]) : 64'd0);
    check("cyc_ovf", 64'(covf), 64'(mflags()));
    check("cyc_irq", 64'(oint), 64'(|mflags()));
  end

  task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [E-1:0] e = '0);
    @(posedge clk); #1;
    we = 1; re = 0; addr = a; wd = d; ev = e;
  endtask

  task automatic run(input int cycles, input logic [E-1:0] e);
    repeat (cycles) begin
      @(posedge clk); #1;
      we = 0; re = 0; ev = e;
    end
  endtask

  task automatic rd_lit(input string name, input logic [11:0] a, input logic [31:0] exp,
                        input bit exp_req = 1);
    logic [32:0] m;
    @(posedge clk); #1;
    we = 0; re = 1; addr = a; ev = '0;
    #1;
    m = mread(a);
    check({name, "_req"}, 64'(req), 64'(exp_req));
    check(name, 64'(rd), 64'(exp));
    check({name, "_model"}, 64'(m[31:0]), 64'(exp));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [11:0] ra;
    int r;
    repeat (3) @(posedge clk);
    #1 rst = 1;

    // Reset contents and out-of-range addresses
    for (int n = 0; n < C; n++) begin
      rd_lit("rst_lo", LO + 12'(n), 32'h0);
      rd_lit("rst_hi", HI + 12'(n), 32'h0);
      rd_lit("rst_sel", EVA + 12'(n), 32'h0);
    end
    rd_lit("rst_inh", INH, 32'h0);
    rd_lit("lo_oob", LO + 12'(C), 32'h0, 0);
    rd_lit("hi_oob", HI + 12'(C), 32'h0, 0);
    rd_lit("sel_oob", EVA + 12'(C), 32'h0, 0);

    // Event selection
    wr(EVA + 12'd1, 32'd3);
    run(5, 16'h0005);
    rd_lit("sel3_cnt1", LO + 12'd1, 32'd5);
    rd_lit("sel3_cnt0", LO, 32'd0);
    rd_lit("sel3_cnt2", LO + 12'd2, 32'd0);
    wr(EVA + 12'd1, E + 1);
    rd_lit("sel_big_rb", EVA + 12'd1, E + 1);
    run(3, '1);
    rd_lit("sel_big_cnt", LO + 12'd1, 32'd5);
    wr(EVA + 12'd1, 32'hFFFF_FFE3);
    rd_lit("sel_trunc", EVA + 12'd1, 32'd3);
    wr(EVA + 12'd1, 32'd0);

    // Carry into the upper half, inhibit, upper truncation
    wr(LO, 32'hFFFF_FFFE);
    wr(HI, 32'h0);
    wr(EVA, 32'd1);
    run(3, 16'h0001);
    rd_lit("carry_lo", LO, 32'h1);
    rd_lit("carry_hi", HI, 32'h1);
    wr(INH, 32'h8);
    run(3, 16'h0001);
    rd_lit("inh_lo", LO, 32'h1);
    rd_lit("inh_rb", INH, 32'h8);
    wr(INH, 32'hFFFF_FFFF);
    rd_lit("inh_mask", INH, 32'h78);
    wr(INH, 32'h0);
    wr(HI, 32'hFFFF_FFFF);
    rd_lit("hi_trunc", HI, 32'h0000_FFFF);
    rd_lit("hi_trunc_lo", LO, 32'h1);

    // Write beats increment; same-cycle read sees the old value
    wr(EVA + 12'd2, 32'd2);
    wr(LO + 12'd2, 32'h55);
    @(posedge clk); #1;
    we = 1; re = 1; addr = LO + 12'd2; wd = 32'h100; ev = 16'h0002;
    #1;
    check("rw_same_cycle", 64'(rd), 64'h55);
    rd_lit("wr_beats_inc", LO + 12'd2, 32'h100);

`ifdef CSR_COUNTER_OVERFLOW_EN
    wr(EVA + 12'd3, 32'd4);
    wr(LO + 12'd3, 32'hFFFF_FFFF);
    wr(HI + 12'd3, 32'hFFFF_FFFF);
    run(1, 16'h0008);
    rd_lit("wrap_lo", LO + 12'd3, 32'h0);
    check("wrap_flag", 64'(covf), 64'h8);
    check("wrap_irq", 64'(oint), 64'h1);
    rd_lit("ovf_rb", OVF, 32'h40);
    wr(OVF, 32'h40);
    rd_lit("ovf_clr", OVF, 32'h0);
    check("ovf_clr_irq", 64'(oint), 64'h0);
    wr(LO + 12'd3, 32'hFFFF_FFFF);
    wr(HI + 12'd3, 32'hFFFF_FFFF);
    wr(OVF, 32'h40, 16'h0008);
    rd_lit("set_beats_clr", OVF, 32'h40);
    wr(OVF, 32'hFFFF_FFFF);
    rd_lit("ovf_clr2", OVF, 32'h0);
`else
    rd_lit("ovf_unmapped", OVF, 32'h0, 0);
    check("ovf_tied", 64'(covf), 64'h0);
`endif

    // Asynchronous reset mid-count
    wr(EVA, 32'd1);
    wr(EVA + 12'd1, 32'd1);
    run(4, '1);
    @(posedge clk); #2;
    rst = 0; re = 1; addr = LO;
    #1;
    check("arst_req", 64'(req), 64'h0);
    check("arst_rd", 64'(rd), 64'h0);
    check("arst_ovf", 64'(covf), 64'h0);
    check("arst_irq", 64'(oint), 64'h0);
    @(posedge clk); #1 rst = 1;
    rd_lit("arst_cnt0", LO, 32'h0);
    rd_lit("arst_sel0", EVA, 32'h0);
    rd_lit("arst_inh", INH, 32'h0);
    run(3, '1);
    rd_lit("arst_nocount", LO, 32'h0);
    wr(EVA, 32'd1);
    run(3, '1);
    rd_lit("arst_resume", LO, 32'h3);

    // Random traffic, checked every cycle by the compare process
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      r  = $urandom_range(0, C);
      we = ($urandom % 3) == 0;
      re = $urandom % 2;
      ev = E'($urandom);
      wd = $urandom;
      case ($urandom % 8)
        0: ra = LO + 12'(r);
        1: begin ra = HI + 12'(r); if ($urandom % 2) wd = 32'hFFFF_FFFF; end
        2, 3: begin ra = EVA + 12'(r); wd = $urandom % 20; end
        4: begin ra = INH; wd = $urandom & $urandom & $urandom; end
        5: ra = OVF;
        6: ra = 12'($urandom);
        default: begin ra = LO + 12'(r); wd = 32'hFFFF_FFFF; end
      endcase
      addr = ra;
    end

    @(posedge clk); #1;
    we = 0; re = 0; ev = '0;
    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
